// File: rtl/idu_pipe.sv
// Instruction-decode stage: combinational RISC-V decode of the IFU word, captured into a
// 2-entry FIFO so EXU back-pressure never reaches in_ready combinationally.
module idu_pipe #(
    parameter int XLEN   = 64,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_cls,
    output logic            out_word,
    output logic            out_rd_w_en,
    output logic            out_illegal,
    output logic [1:0]      count
);

    localparam logic [3:0] CLS_OP = 4'd0,  CLS_OPIMM = 4'd1, CLS_LOAD  = 4'd2,  CLS_STORE = 4'd3;
    localparam logic [3:0] CLS_BR = 4'd4,  CLS_JAL   = 4'd5, CLS_JALR  = 4'd6,  CLS_LUI   = 4'd7;
    localparam logic [3:0] CLS_AUIPC = 4'd8, CLS_SYS = 4'd9, CLS_MULDIV = 4'd10, CLS_MISC = 4'd11;
    localparam logic [3:0] CLS_ILL = 4'd15;
    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      cls;
        logic            word;
        logic            rd_w_en;
    } idu_ent_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            is_shift, shamt_ok, f7_ok, ill, writes;
    idu_ent_t        dec;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    // Size casts of signed operands sign-extend from inst[31] up to XLEN.
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign shamt_ok = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
    assign f7_ok    = (f7 == 7'b0000000)
                    || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))
                    || ((f7 == 7'b0000001) && EN_M);

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.rd     = in_inst[11:7];
        dec.funct3 = f3;
        dec.cls    = CLS_ILL;
        ill        = 1'b0;
        writes     = 1'b0;
        // Every listed opcode ends in 2'b11, so a compressed encoding falls to default.
        case (opc)
            7'b0000011: begin dec.cls = CLS_LOAD;  dec.imm = imm_i; writes = 1'b1;
                              ill = !RV64 && ((f3 == 3'b011) || (f3 == 3'b110)); end
            7'b0001111: begin dec.cls = CLS_MISC;  dec.imm = imm_i; end
            7'b0010011: begin dec.cls = CLS_OPIMM; dec.imm = imm_i; writes = 1'b1;
                              ill = is_shift && (!shamt_ok || (!RV64 && in_inst[25])); end
            7'b0010111: begin dec.cls = CLS_AUIPC; dec.imm = imm_u; writes = 1'b1; end
            7'b0011011: begin dec.cls = CLS_OPIMM; dec.imm = imm_i; writes = 1'b1; dec.word = 1'b1;
                              ill = !RV64 || (is_shift && !shamt_ok); end
            7'b0100011: begin dec.cls = CLS_STORE; dec.imm = imm_s;
                              ill = !RV64 && (f3 == 3'b011); end
            7'b0110011: begin dec.cls = (f7 == 7'b0000001) ? CLS_MULDIV : CLS_OP; writes = 1'b1;
                              ill = !f7_ok; end
            7'b0110111: begin dec.cls = CLS_LUI;   dec.imm = imm_u; writes = 1'b1; end
            7'b0111011: begin dec.cls = (f7 == 7'b0000001) ? CLS_MULDIV : CLS_OP; writes = 1'b1;
                              dec.word = 1'b1; ill = !f7_ok || !RV64; end
            7'b1100011: begin dec.cls = CLS_BR;    dec.imm = imm_b; end
            7'b1100111: begin dec.cls = CLS_JALR;  dec.imm = imm_i; writes = 1'b1; end
            7'b1101111: begin dec.cls = CLS_JAL;   dec.imm = imm_j; writes = 1'b1; end
            7'b1110011: begin dec.cls = CLS_SYS;   dec.imm = imm_i; writes = 1'b1;
                              ill = (f3 == 3'b100) || (!EN_CSR && (f3 != 3'b000)); end
            default:    ill = 1'b1;
        endcase
        if (ill) begin
            dec.cls = CLS_ILL;
            dec.imm = '0;
            writes  = 1'b0;
        end
        dec.rd_w_en = writes && (in_inst[11:7] != 5'd0);
    end

    idu_ent_t mem [2];
    logic     head, tail, push, pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= dec;
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign out_pc      = mem[head].pc;
    assign out_imm     = mem[head].imm;
    assign out_rs1     = mem[head].rs1;
    assign out_rs2     = mem[head].rs2;
    assign out_rd      = mem[head].rd;
    assign out_funct3  = mem[head].funct3;
    assign out_cls     = mem[head].cls;
    assign out_word    = mem[head].word;
    assign out_rd_w_en = mem[head].rd_w_en;
    assign out_illegal = (mem[head].cls == CLS_ILL);

endmodule

// File: tb/tb_idu_pipe.sv
// Directed-vector bench for idu_pipe: RV64 full-featured, RV32, and no-M/no-CSR instances
// share one stimulus stream; FIFO corner cases and a random legal stream use the RV64 one.
module tb_idu_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    always #5 clk = ~clk;

    logic        i_ready, o_valid, o_word, o_wen, o_ill;
    logic [63:0] o_pc, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_f3;
    logic [3:0]  o_cls;
    logic [1:0]  o_cnt;

    logic        a_ready, a_valid, a_word, a_wen, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [3:0]  a_cls;
    logic [1:0]  a_cnt;

    logic        n_ready, n_valid, n_word, n_wen, n_ill;
    logic [63:0] n_pc, n_imm;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    logic [2:0]  n_f3;
    logic [3:0]  n_cls;
    logic [1:0]  n_cnt;

    idu_pipe #(.XLEN(64), .EN_M(1'b1), .EN_CSR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(i_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(o_valid), .out_ready(out_ready),
        .out_pc(o_pc), .out_imm(o_imm), .out_rs1(o_rs1), .out_rs2(o_rs2), .out_rd(o_rd),
        .out_funct3(o_f3), .out_cls(o_cls), .out_word(o_word), .out_rd_w_en(o_wen),
        .out_illegal(o_ill), .count(o_cnt));

    idu_pipe #(.XLEN(32), .EN_M(1'b1), .EN_CSR(1'b1)) u_d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
        .in_pc(in_pc[31:0]), .in_inst(in_inst), .out_valid(a_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_funct3(a_f3), .out_cls(a_cls), .out_word(a_word), .out_rd_w_en(a_wen),
        .out_illegal(a_ill), .count(a_cnt));

    idu_pipe #(.XLEN(64), .EN_M(1'b0), .EN_CSR(1'b0)) u_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(n_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_imm(n_imm), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_rd(n_rd),
        .out_funct3(n_f3), .out_cls(n_cls), .out_word(n_word), .out_rd_w_en(n_wen),
        .out_illegal(n_ill), .count(n_cnt));

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [63:0] imm;
        logic        wen;
        logic        word;
        logic [3:0]  cls32;
        logic [3:0]  clsnm;
    } vec_t;

    vec_t vt [24];
    int   n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
    endtask

    initial begin
        logic [31:0] ii;
        logic [31:0] exp32;
        int          pool[$];
        int          q_idx[$];
        logic [63:0] q_pc[$];
        int          cur_idx, sent, cyc;
        logic [63:0] cur_pc;
        bit          pend;

        //              inst          cls    imm                      wen  word cls32  clsnm
        vt[0]  = '{32'hFFF00093, 4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd1,  4'd1 };
        vt[1]  = '{32'h002080BB, 4'd0,  64'h0,                   1'b1, 1'b1, 4'd15, 4'd0 };
        vt[2]  = '{32'h022080B3, 4'd10, 64'h0,                   1'b1, 1'b0, 4'd10, 4'd15};
        vt[3]  = '{32'hFFDFF06F, 4'd5,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 4'd5,  4'd5 };
        vt[4]  = '{32'h123452B7, 4'd7,  64'h0000_0000_1234_5000, 1'b1, 1'b0, 4'd7,  4'd7 };
        vt[5]  = '{32'h800002B7, 4'd7,  64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 4'd7,  4'd7 };
        vt[6]  = '{32'h0020A423, 4'd3,  64'h8,                   1'b0, 1'b0, 4'd3,  4'd3 };
        vt[7]  = '{32'hFE20AE23, 4'd3,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 4'd3,  4'd3 };
        vt[8]  = '{32'hFE208CE3, 4'd4,  64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 4'd4,  4'd4 };
        vt[9]  = '{32'h0100B183, 4'd2,  64'h10,                  1'b1, 1'b0, 4'd15, 4'd2 };
        vt[10] = '{32'h300110F3, 4'd9,  64'h300,                 1'b1, 1'b0, 4'd9,  4'd15};
        vt[11] = '{32'h00004073, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};
        vt[12] = '{32'h00100090, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};
        vt[13] = '{32'h403100B3, 4'd0,  64'h0,                   1'b1, 1'b0, 4'd0,  4'd0 };
        vt[14] = '{32'h403110B3, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};
        vt[15] = '{32'h42115093, 4'd1,  64'h421,                 1'b1, 1'b0, 4'd15, 4'd1 };
        vt[16] = '{32'h04011093, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};
        vt[17] = '{32'h00000013, 4'd1,  64'h0,                   1'b0, 1'b0, 4'd1,  4'd1 };
        vt[18] = '{32'h00001097, 4'd8,  64'h1000,                1'b1, 1'b0, 4'd8,  4'd8 };
        vt[19] = '{32'h004100E7, 4'd6,  64'h4,                   1'b1, 1'b0, 4'd6,  4'd6 };
        vt[20] = '{32'h0FF0000F, 4'd11, 64'hFF,                  1'b0, 1'b0, 4'd11, 4'd11};
        vt[21] = '{32'h0000007F, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};
        vt[22] = '{32'h022080BB, 4'd10, 64'h0,                   1'b1, 1'b1, 4'd15, 4'd15};
        vt[23] = '{32'h042080B3, 4'd15, 64'h0,                   1'b0, 1'b0, 4'd15, 4'd15};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst count", 64'(o_cnt), 64'd0);
        chk("rst out_valid", 64'(o_valid), 64'd0);
        chk("rst in_ready", 64'(i_ready), 64'd1);
        chk("rst out_pc", o_pc, 64'd0);
        chk("rst out_imm", o_imm, 64'd0);
        chk("rst out_cls", 64'(o_cls), 64'd0);
        chk("rst out_illegal", 64'(o_ill), 64'd0);
        rst_n = 1'b1;

        // Decode table: one instruction per pass, head checked the cycle after accept
        foreach (vt[i]) begin
            ii = vt[i].inst;
            push_one(ii, 64'h8000_0000_0000_1000 + 64'(i * 4));
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), 64'(o_valid), 64'd1);
            chk($sformatf("v%0d pc", i), o_pc, 64'h8000_0000_0000_1000 + 64'(i * 4));
            chk($sformatf("v%0d cls", i), 64'(o_cls), 64'(vt[i].cls));
            chk($sformatf("v%0d imm", i), o_imm, vt[i].imm);
            chk($sformatf("v%0d rd_w_en", i), 64'(o_wen), 64'(vt[i].wen));
            chk($sformatf("v%0d word", i), 64'(o_word), 64'(vt[i].word));
            chk($sformatf("v%0d illegal", i), 64'(o_ill), 64'(vt[i].cls == 4'd15));
            chk($sformatf("v%0d fields", i), 64'({o_rs1, o_rs2, o_rd, o_f3}),
                64'({ii[19:15], ii[24:20], ii[11:7], ii[14:12]}));
            exp32 = (vt[i].cls32 == 4'd15) ? 32'h0 : vt[i].imm[31:0];
            chk($sformatf("v%0d rv32 cls", i), 64'(a_cls), 64'(vt[i].cls32));
            chk($sformatf("v%0d rv32 imm", i), 64'(a_imm), 64'(exp32));
            chk($sformatf("v%0d rv32 rd_w_en", i), 64'(a_wen),
                64'(vt[i].wen && (vt[i].cls32 != 4'd15)));
            chk($sformatf("v%0d noM cls", i), 64'(n_cls), 64'(vt[i].clsnm));
        end
        @(negedge clk);
        chk("drain count", 64'(o_cnt), 64'd0);

        // Back-pressure: fill, hold a third offer, release
        out_ready = 1'b0;
        push_one(vt[0].inst, 64'hA0);
        push_one(vt[4].inst, 64'hA4);
        chk("bp count1", 64'(o_cnt), 64'd1);
        push_one(vt[6].inst, 64'hA8);
        chk("bp count2", 64'(o_cnt), 64'd2);
        chk("bp in_ready full", 64'(i_ready), 64'd0);
        @(negedge clk);
        chk("bp hold count", 64'(o_cnt), 64'd2);
        chk("bp head A", o_pc, 64'hA0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp after pop count", 64'(o_cnt), 64'd1);
        chk("bp in_ready back", 64'(i_ready), 64'd1);
        chk("bp head B", o_pc, 64'hA4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp push+pop count", 64'(o_cnt), 64'd1);
        chk("bp head C", o_pc, 64'hA8);
        chk("bp head C cls", 64'(o_cls), 64'd3);
        @(negedge clk);
        chk("bp empty", 64'(o_valid), 64'd0);

        // Flush while full with a simultaneous offer
        out_ready = 1'b0;
        push_one(vt[0].inst, 64'hB0);
        push_one(vt[0].inst, 64'hB4);
        @(negedge clk);
        chk("fl full count", 64'(o_cnt), 64'd2);
        flush = 1'b1; in_valid = 1'b1; in_pc = 64'hB8; in_inst = vt[4].inst;
        chk("fl in_ready ungated", 64'(i_ready), 64'd0);
        chk("fl out_valid ungated", 64'(o_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl count", 64'(o_cnt), 64'd0);
        chk("fl out_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        chk("fl stays empty", 64'(o_cnt), 64'd0);

        // Flush with one entry and an acceptable offer: offer dropped, pointers rewound
        push_one(vt[0].inst, 64'hC0);
        @(negedge clk);
        chk("fl1 count", 64'(o_cnt), 64'd1);
        flush = 1'b1; in_pc = 64'hC4;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1 count0", 64'(o_cnt), 64'd0);
        push_one(vt[18].inst, 64'hC8);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl1 next pc", o_pc, 64'hC8);
        chk("fl1 next cls", 64'(o_cls), 64'd8);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl1 drained", 64'(o_cnt), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push_one(vt[4].inst, 64'hD0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst count", 64'(o_cnt), 64'd0);
        chk("arst out_pc", o_pc, 64'd0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        push_one(vt[19].inst, 64'hD4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("arst resume pc", o_pc, 64'hD4);
        chk("arst resume count", 64'(o_cnt), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);

        // Random legal stream with random back-pressure
        foreach (vt[i]) if (vt[i].cls != 4'd15) pool.push_back(i);
        sent = 0; cyc = 0; pend = 1'b0; cur_idx = 0; cur_pc = '0;
        while ((sent < 100 || q_pc.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < 100 && $urandom_range(0, 3) != 0) begin
                cur_idx = pool[$urandom_range(0, pool.size() - 1)];
                cur_pc  = {$urandom, $urandom};
                pend    = 1'b1;
            end
            in_valid = pend; in_inst = vt[cur_idx].inst; in_pc = cur_pc;
            out_ready = ($urandom_range(0, 1) == 1);
            if (o_cnt > 2'd2) chk("rnd count<=2", 64'(o_cnt), 64'd2);
            if (o_valid && out_ready) begin
                if (q_pc.size() == 0) chk("rnd spurious pop", 64'(o_valid), 64'd0);
                else begin
                    chk("rnd pc order", o_pc, q_pc.pop_front());
                    chk("rnd cls", 64'(o_cls), 64'(vt[q_idx.pop_front()].cls));
                end
            end
            if (pend && i_ready) begin
                q_pc.push_back(cur_pc);
                q_idx.push_back(cur_idx);
                sent++;
                pend = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("rnd all sent", 64'(sent), 64'd100);
        chk("rnd all drained", 64'(q_pc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
